if_id_fetch_buffer: RTL and testbench

Fetch-side stage directly downstream of the program counter. Each cycle it issues the current PC to synchronous instruction memory, captures the returned word one cycle later, and buffers {pc, instruction} pairs in a small circular queue feeding the IF/ID boundary of the decode stage. It throttles the PC with pc_hold, absorbs decode stalls without losing or duplicating instructions, and squashes all wrong-path state on a taken branch.

---
 rtl/if_id_fetch_buffer.sv | 106 ++++++++++
 tb/tb_if_id_fetch_buffer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/if_id_fetch_buffer.sv
// Fetch buffer between the PC and decode: issues the PC to synchronous IMEM,
// pairs each returned word with its PC and queues the pairs for the IF/ID boundary.
module if_id_fetch_buffer #(
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 2
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [ADDR_W-1:0]          pc_in,
    output logic                       pc_hold,
    output logic                       imem_req,
    output logic [ADDR_W-1:0]          imem_addr,
    input  logic [INSTR_W-1:0]         imem_rdata,
    input  logic                       flush,
    input  logic                       id_ready,
    output logic                       id_valid,
    output logic [ADDR_W-1:0]          id_pc,
    output logic [INSTR_W-1:0]         id_instr,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W:0]   DEPTH_EXT = (CNT_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);

    logic [CNT_W-1:0]   r_count;
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic               r_inflight;
    logic [ADDR_W-1:0]  r_inflightPc;
    logic [ADDR_W-1:0]  r_qPc    [DEPTH];
    logic [INSTR_W-1:0] r_qInstr [DEPTH];

    logic               w_pop;
    logic               w_push;
    logic [CNT_W:0]     w_pending;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // A request is only issued when its response is guaranteed a free slot,
    // counting the word already in flight and any entry leaving this cycle.
    always_comb begin
        w_pop     = id_valid & id_ready & ~flush;
        w_push    = r_inflight & ~flush;
        w_pending = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight} - {{CNT_W{1'b0}}, w_pop};
        imem_req  = reset_n & ~flush & (w_pending < DEPTH_EXT);
        pc_hold   = ~imem_req;
    end

    assign imem_addr = pc_in;
    assign id_valid  = (r_count != '0);
    assign id_pc     = id_valid ? r_qPc[r_head] : '0;
    assign id_instr  = id_valid ? r_qInstr[r_head] : '0;
    assign occupancy = r_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_qPc[i]    <= '0;
                r_qInstr[i] <= '0;
            end
        end else if (w_push) begin
            r_qPc[r_tail]    <= r_inflightPc;
            r_qInstr[r_tail] <= imem_rdata;
        end
    end

    // A flush squashes the queue and the in-flight response in one edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count      <= '0;
            r_head       <= '0;
            r_tail       <= '0;
            r_inflight   <= 1'b0;
            r_inflightPc <= '0;
        end else begin
            r_inflight   <= imem_req;
            r_inflightPc <= pc_in;
            if (flush) begin
                r_count <= '0;
                r_head  <= '0;
                r_tail  <= '0;
            end else begin
                if (w_push) begin
                    r_tail <= nextPtr(r_tail);
                end
                if (w_pop) begin
                    r_head <= nextPtr(r_head);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + CNT_W'(1);
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - CNT_W'(1);
                end
            end
        end
    end

    noOverflow: assert property (@(posedge clock) disable iff (!reset_n)
        !(w_push && !w_pop && (r_count == FULL_CNT)));

endmodule

// File: tb/tb_if_id_fetch_buffer.sv
// Randomized bench for if_id_fetch_buffer: a DEPTH=2 and a DEPTH=3 instance run
// side by side against a queue-level reference model of the fetch buffer.
module tb_if_id_fetch_buffer;
    localparam int ADDR_W  = 64;
    localparam int INSTR_W = 32;
    localparam int NUM_DUT = 2;
    localparam int DEPTH_A = 2;
    localparam int DEPTH_B = 3;

    logic               clock = 1'b0;
    logic               resetN;
    logic               flush;
    logic               idReady;
    logic [ADDR_W-1:0]  pcIn      [NUM_DUT];
    logic [INSTR_W-1:0] imemRdata [NUM_DUT];
    logic [NUM_DUT-1:0] pcHold;
    logic [NUM_DUT-1:0] imemReq;
    logic [NUM_DUT-1:0] idValid;
    logic [ADDR_W-1:0]  imemAddr  [NUM_DUT];
    logic [ADDR_W-1:0]  idPc      [NUM_DUT];
    logic [INSTR_W-1:0] idInstr   [NUM_DUT];
    logic [1:0]         occupancy [NUM_DUT];

    logic [ADDR_W-1:0]  modelQ          [NUM_DUT][$];
    logic               modelInflight   [NUM_DUT];
    logic [ADDR_W-1:0]  modelInflightPc [NUM_DUT];

    int assertCount = 0;
    int failCount   = 0;

    always #5 clock = ~clock;

    if_id_fetch_buffer #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH_A)) dutA (
        .clock(clock), .reset_n(resetN), .pc_in(pcIn[0]), .pc_hold(pcHold[0]),
        .imem_req(imemReq[0]), .imem_addr(imemAddr[0]), .imem_rdata(imemRdata[0]),
        .flush(flush), .id_ready(idReady), .id_valid(idValid[0]), .id_pc(idPc[0]),
        .id_instr(idInstr[0]), .occupancy(occupancy[0])
    );

    if_id_fetch_buffer #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH_B)) dutB (
        .clock(clock), .reset_n(resetN), .pc_in(pcIn[1]), .pc_hold(pcHold[1]),
        .imem_req(imemReq[1]), .imem_addr(imemAddr[1]), .imem_rdata(imemRdata[1]),
        .flush(flush), .id_ready(idReady), .id_valid(idValid[1]), .id_pc(idPc[1]),
        .id_instr(idInstr[1]), .occupancy(occupancy[1])
    );

    function automatic int depthOf(input int i);
        return (i == 0) ? DEPTH_A : DEPTH_B;
    endfunction

    function automatic logic [INSTR_W-1:0] memWord(input logic [ADDR_W-1:0] addr);
        return 32'h8B00_0000 + addr[31:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare every output against the model,
    // then advance the model, the memory and the PC across the edge.
    task automatic applyStimulus(input logic ready, input logic fl, input logic [ADDR_W-1:0] target);
        logic [NUM_DUT-1:0] popNow;
        logic [NUM_DUT-1:0] reqNow;
        logic [NUM_DUT-1:0] holdSeen;
        logic [NUM_DUT-1:0] reqSeen;
        logic [ADDR_W-1:0]  addrSeen [NUM_DUT];
        idReady = ready;
        flush   = fl;
        #2;
        for (int i = 0; i < NUM_DUT; i++) begin
            int sz;
            logic [ADDR_W-1:0] headPc;
            sz        = modelQ[i].size();
            headPc    = (sz != 0) ? modelQ[i][0] : '0;
            popNow[i] = (sz != 0) && idReady && !flush;
            reqNow[i] = resetN && !flush &&
                        ((sz + int'(modelInflight[i]) - int'(popNow[i])) < depthOf(i));
            checkOutput($sformatf("idValid%0d", i), 64'(idValid[i]), 64'(sz != 0));
            checkOutput($sformatf("idPc%0d", i), idPc[i], headPc);
            checkOutput($sformatf("idInstr%0d", i), 64'(idInstr[i]),
                        (sz != 0) ? 64'(memWord(headPc)) : 64'd0);
            checkOutput($sformatf("occupancy%0d", i), 64'(occupancy[i]), 64'(sz));
            checkOutput($sformatf("imemReq%0d", i), 64'(imemReq[i]), 64'(reqNow[i]));
            checkOutput($sformatf("pcHold%0d", i), 64'(pcHold[i]), 64'(!reqNow[i]));
            checkOutput($sformatf("imemAddr%0d", i), imemAddr[i], pcIn[i]);
            holdSeen[i] = pcHold[i];
            reqSeen[i]  = imemReq[i];
            addrSeen[i] = imemAddr[i];
        end
        @(posedge clock);
        #1;
        for (int i = 0; i < NUM_DUT; i++) begin
            if (flush) begin
                modelQ[i].delete();
                modelInflight[i] = 1'b0;
            end else begin
                if (popNow[i]) begin
                    void'(modelQ[i].pop_front());
                end
                if (modelInflight[i]) begin
                    modelQ[i].push_back(modelInflightPc[i]);
                end
                modelInflight[i] = reqNow[i];
            end
            modelInflightPc[i] = pcIn[i];
            if (reqSeen[i]) begin
                imemRdata[i] = memWord(addrSeen[i]);
            end
            if (flush) begin
                pcIn[i] = target;
            end else if (!holdSeen[i]) begin
                pcIn[i] = pcIn[i] + 64'd1;
            end
        end
    endtask

    // Asserts reset between edges (with flush high, which reset must override)
    // and checks the outputs clear without waiting for a clock edge.
    task automatic doReset(input logic [ADDR_W-1:0] startPc);
        #2;
        resetN = 1'b0;
        flush  = 1'b1;
        #1;
        for (int i = 0; i < NUM_DUT; i++) begin
            checkOutput($sformatf("rstIdValid%0d", i), 64'(idValid[i]), 64'd0);
            checkOutput($sformatf("rstOccupancy%0d", i), 64'(occupancy[i]), 64'd0);
            checkOutput($sformatf("rstImemReq%0d", i), 64'(imemReq[i]), 64'd0);
            checkOutput($sformatf("rstPcHold%0d", i), 64'(pcHold[i]), 64'd1);
            checkOutput($sformatf("rstIdPc%0d", i), idPc[i], 64'd0);
            checkOutput($sformatf("rstIdInstr%0d", i), 64'(idInstr[i]), 64'd0);
            modelQ[i].delete();
            modelInflight[i]   = 1'b0;
            modelInflightPc[i] = '0;
            pcIn[i]            = startPc;
        end
        @(posedge clock);
        #1;
        flush  = 1'b0;
        resetN = 1'b1;
    endtask

    initial begin
        void'($urandom(32'd2024));
        resetN  = 1'b1;
        flush   = 1'b0;
        idReady = 1'b0;
        for (int i = 0; i < NUM_DUT; i++) begin
            pcIn[i]      = '0;
            imemRdata[i] = '0;
        end
        #1;
        doReset(64'd0);

        for (int c = 0; c < 12; c++) applyStimulus(1'b1, 1'b0, '0);
        for (int c = 0; c < 5; c++)  applyStimulus(1'b0, 1'b0, '0);
        for (int c = 0; c < 6; c++)  applyStimulus(1'b1, 1'b0, '0);

        for (int c = 0; c < 3; c++)  applyStimulus(1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b1, 64'h40);
        for (int c = 0; c < 6; c++)  applyStimulus(1'b1, 1'b0, '0);

        for (int c = 0; c < 4; c++)  applyStimulus(1'b0, 1'b0, '0);
        for (int c = 0; c < 6; c++)  applyStimulus(1'b1, 1'b0, '0);

        for (int c = 0; c < 4; c++)  applyStimulus(1'b0, 1'b0, '0);
        doReset(64'h100);
        for (int c = 0; c < 6; c++)  applyStimulus(1'b1, 1'b0, '0);

        for (int c = 0; c < 120; c++) begin
            logic rdy;
            logic fl;
            rdy = 1'($urandom_range(0, 1));
            fl  = ($urandom_range(0, 15) == 0);
            applyStimulus(rdy, fl, 64'($urandom_range(0, 4095)));
        end
        for (int c = 0; c < 6; c++)  applyStimulus(1'b1, 1'b0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
